// File: rtl/cdma_multiuser_receiver.sv
// rtl/cdma_multiuser_receiver.sv - N-user DSSS despreader with saturating correlators and dead-zone decisions.
// Soft correlation output is built only when CDMA_RX_SOFT_OUT_EN is defined.
module cdma_multiuser_receiver #(
  parameter int NUM_USERS = 2,
  parameter int SAMPLE_W  = 8,
  parameter int PN_W      = 6,
  parameter int SF_LOG2   = 6,
  parameter int ACC_W     = 16,
  parameter int SAT_LIMIT = 5000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [SAMPLE_W-1:0]    sample_in,
  input  logic                          sample_valid,
  input  logic                          sync,
  input  logic [NUM_USERS*PN_W-1:0]     user_codes,
  input  logic [NUM_USERS-1:0]          user_en,
  input  logic [ACC_W-1:0]              thresh,
  output logic [NUM_USERS-1:0]          data_out,
  output logic [NUM_USERS-1:0]          data_valid,
  output logic [NUM_USERS-1:0]          erasure,
  output logic                          symbol_done,
  output logic [NUM_USERS*ACC_W-1:0]    corr_out,
  output logic                          state_o
);
  typedef enum logic {S_IDLE = 1'b0, S_TRACK = 1'b1} state_e;

  localparam logic [PN_W-1:0]        PN_SEED   = '1;
  localparam logic [SF_LOG2-1:0]     LAST_CHIP = '1;
  localparam logic signed [ACC_W:0]  SAT_POS   = (ACC_W+1)'(SAT_LIMIT);
  localparam logic signed [ACC_W:0]  SAT_NEG   = -SAT_POS;

  state_e                   state_q, state_d;
  logic [PN_W-1:0]          pn_q, pn_d, pn_cur;
  logic [SF_LOG2-1:0]       cnt_q, cnt_d, cnt_cur;
  logic signed [ACC_W-1:0]  acc_q [NUM_USERS];
  logic signed [ACC_W-1:0]  acc_d [NUM_USERS];
  logic signed [ACC_W-1:0]  sum_w [NUM_USERS];
  logic [NUM_USERS-1:0]     above, below;
  logic [NUM_USERS-1:0]     data_out_q, data_valid_q, erasure_q;
  logic                     symbol_done_q;
  logic                     accept, last;
  logic signed [SAMPLE_W:0] samp_x;
  logic signed [ACC_W+1:0]  th_pos, th_neg;

  // Widened by one bit so negating the most negative sample cannot wrap.
  assign samp_x = {sample_in[SAMPLE_W-1], sample_in};
  assign th_pos = $signed({2'b00, thresh});
  assign th_neg = -th_pos;

  function automatic logic signed [ACC_W-1:0] chip_sum(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [SAMPLE_W:0] s,
    input logic                     neg
  );
    logic signed [ACC_W:0] raw;
    raw = (ACC_W+1)'(acc) + (ACC_W+1)'(neg ? -s : s);
    if (raw > SAT_POS)      chip_sum = SAT_POS[ACC_W-1:0];
    else if (raw < SAT_NEG) chip_sum = SAT_NEG[ACC_W-1:0];
    else                    chip_sum = ACC_W'(raw);
  endfunction

  always_comb begin
    state_d = state_q;
    if (sync) state_d = S_TRACK;
  end

  // A sync restarts the symbol in the same cycle, so its chip uses the seed PN.
  always_comb begin
    pn_cur  = sync ? PN_SEED : pn_q;
    cnt_cur = sync ? '0 : cnt_q;
    accept  = sample_valid && (sync || state_q == S_TRACK);
    last    = accept && !sync && (cnt_q == LAST_CHIP);
    pn_d    = pn_cur;
    cnt_d   = cnt_cur;
    if (accept) begin
      pn_d  = {pn_cur[PN_W-2:0], pn_cur[PN_W-1] ^ pn_cur[PN_W-2]};
      cnt_d = cnt_cur + SF_LOG2'(1);
    end
  end

  always_comb begin
    above = '0;
    below = '0;
    for (int u = 0; u < NUM_USERS; u++) begin
      sum_w[u] = '0;
      if (user_en[u])
        sum_w[u] = chip_sum(sync ? '0 : acc_q[u], samp_x,
                            ~^(pn_cur & user_codes[u*PN_W +: PN_W]));
      above[u] = (ACC_W+2)'(sum_w[u]) > th_pos;
      below[u] = (ACC_W+2)'(sum_w[u]) < th_neg;
      acc_d[u] = sync ? '0 : acc_q[u];
      if (accept) acc_d[u] = last ? '0 : sum_w[u];
      if (!user_en[u]) acc_d[u] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pn_q          <= PN_SEED;
      cnt_q         <= '0;
      data_out_q    <= '0;
      data_valid_q  <= '0;
      erasure_q     <= '0;
      symbol_done_q <= 1'b0;
      for (int u = 0; u < NUM_USERS; u++) acc_q[u] <= '0;
    end else begin
      state_q       <= state_d;
      pn_q          <= pn_d;
      cnt_q         <= cnt_d;
      data_valid_q  <= '0;
      erasure_q     <= '0;
      symbol_done_q <= last;
      for (int u = 0; u < NUM_USERS; u++) begin
        acc_q[u] <= acc_d[u];
        if (last && user_en[u]) begin
          if (above[u]) begin
            data_out_q[u]   <= 1'b1;
            data_valid_q[u] <= 1'b1;
          end else if (below[u]) begin
            data_out_q[u]   <= 1'b0;
            data_valid_q[u] <= 1'b1;
          end else begin
            erasure_q[u]    <= 1'b1;
          end
        end
      end
    end
  end

`ifdef CDMA_RX_SOFT_OUT_EN
  logic [NUM_USERS*ACC_W-1:0] corr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_q <= '0;
    end else if (last) begin
      for (int u = 0; u < NUM_USERS; u++) corr_q[u*ACC_W +: ACC_W] <= sum_w[u];
    end
  end
  assign corr_out = corr_q;
`else
  assign corr_out = '0;
`endif

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign erasure     = erasure_q;
  assign symbol_done = symbol_done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_cdma_multiuser_receiver.sv
// tb/tb_cdma_multiuser_receiver.sv - scoreboard bench for cdma_multiuser_receiver with a symbol-level reference model.
module tb_cdma_multiuser_receiver;
  localparam int NU  = 2;
  localparam int SW  = 8;
  localparam int PW  = 6;
  localparam int AW  = 16;
  localparam int SF  = 64;
  localparam int SAT = 5000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SW-1:0] sample_in = '0;
  logic                 sample_valid = 1'b0;
  logic                 sync = 1'b0;
  logic [NU*PW-1:0]     user_codes = '0;
  logic [NU-1:0]        user_en = '0;
  logic [AW-1:0]        thresh = '0;
  logic [NU-1:0]        data_out, data_valid, erasure;
  logic                 symbol_done;
  logic [NU*AW-1:0]     corr_out;
  logic                 state_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [NU-1:0]    dout;
    logic [NU-1:0]    dv;
    logic [NU-1:0]    er;
    logic [NU*AW-1:0] corr;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model state: chips since sync, current PN word, running sums.
  bit            m_track;
  int            m_cnt;
  logic [PW-1:0] m_pn;
  int            m_acc [NU];
  logic [NU-1:0] m_dout;

  always #5 clk = ~clk;

  cdma_multiuser_receiver dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sync         (sync),
    .user_codes   (user_codes),
    .user_en      (user_en),
    .thresh       (thresh),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .erasure      (erasure),
    .symbol_done  (symbol_done),
    .corr_out     (corr_out),
    .state_o      (state_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int clip(input int x);
    if (x > SAT) return SAT;
    if (x < -SAT) return -SAT;
    return x;
  endfunction

  task automatic model_step(input bit r, input int s, input bit v, input bit sy);
    exp_t e;
    bit   c;
    if (r) begin
      m_track = 1'b0;
      m_cnt   = 0;
      m_pn    = '1;
      m_dout  = '0;
      foreach (m_acc[u]) m_acc[u] = 0;
      return;
    end
    if (sy) begin
      m_track = 1'b1;
      m_cnt   = 0;
      m_pn    = '1;
      foreach (m_acc[u]) m_acc[u] = 0;
    end
    foreach (m_acc[u]) if (!user_en[u]) m_acc[u] = 0;
    if (v && m_track) begin
      for (int u = 0; u < NU; u++) begin
        if (user_en[u]) begin
          c = ^(m_pn & user_codes[u*PW +: PW]);
          m_acc[u] = clip(m_acc[u] + (c ? s : -s));
        end
      end
      if (m_cnt == SF - 1) begin
        e = '0;
        for (int u = 0; u < NU; u++) begin
          if (user_en[u]) begin
            if (m_acc[u] > int'(thresh)) begin
              m_dout[u] = 1'b1;
              e.dv[u]   = 1'b1;
            end else if (m_acc[u] < -int'(thresh)) begin
              m_dout[u] = 1'b0;
              e.dv[u]   = 1'b1;
            end else begin
              e.er[u]   = 1'b1;
            end
          end
`ifdef CDMA_RX_SOFT_OUT_EN
          e.corr[u*AW +: AW] = AW'(m_acc[u]);
`endif
          m_acc[u] = 0;
        end
        e.dout = m_dout;
        exp_q.push_back(e);
      end
      m_cnt = (m_cnt + 1) % SF;
      m_pn  = {m_pn[PW-2:0], m_pn[PW-1] ^ m_pn[PW-2]};
    end
  endtask

  task automatic step(input int s, input bit v, input bit sy);
    sample_in    = SW'(s);
    sample_valid = v;
    sync         = sy;
    @(posedge clk);
    model_step(rst, s, v, sy);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  function automatic int rsamp();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  always @(negedge clk) begin
    if (symbol_done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_symbol_done actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("data_valid", 64'(data_valid), 64'(mon_e.dv));
        check("erasure",    64'(erasure),    64'(mon_e.er));
        check("data_out",   64'(data_out),   64'(mon_e.dout));
        check("corr_out",   64'(corr_out),   64'(mon_e.corr));
      end
    end else if (data_valid != '0 || erasure != '0) begin
      total++;
      bad++;
      $display("FAIL stray_pulse actual=%0h/%0h required=0/0", data_valid, erasure);
    end
  end

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_data_out",    64'(data_out),    64'd0);
    check("rst_data_valid",  64'(data_valid),  64'd0);
    check("rst_erasure",     64'(erasure),     64'd0);
    check("rst_symbol_done", 64'(symbol_done), 64'd0);
    check("rst_corr_out",    64'(corr_out),    64'd0);
    check("rst_state",       64'(state_o),     64'd0);

    user_en    = 2'b01;
    user_codes = '0;
    thresh     = AW'(100);
    repeat (80) step(rsamp(), 1'b1, 1'b0);
    check("idle_state", 64'(state_o), 64'd0);

    step(0, 1'b0, 1'b1);
    check("track_state", 64'(state_o), 64'd1);
    repeat (SF) step(10, 1'b1, 1'b0);
    repeat (SF) step(-128, 1'b1, 1'b0);
    repeat (SF) step(1, 1'b1, 1'b0);

    repeat (30) step(5, 1'b1, 1'b0);
    step(-7, 1'b1, 1'b1);
    repeat (SF - 1) step(-7, 1'b1, 1'b0);

    user_en    = 2'b11;
    user_codes = (NU*PW)'($urandom);
    thresh     = AW'(200);
    for (int i = 0; i < 2 * SF; i++) begin
      step(rsamp(), 1'b1, 1'b0);
      repeat (2) step(rsamp(), 1'b0, 1'b0);
    end

    repeat (40) step(rsamp(), 1'b1, 1'b0);
    do_reset();
    @(negedge clk);
    check("mid_rst_data_out", 64'(data_out), 64'd0);
    check("mid_rst_corr",     64'(corr_out), 64'd0);
    check("mid_rst_state",    64'(state_o),  64'd0);
    repeat (SF + 10) step(rsamp(), 1'b1, 1'b0);
    check("post_rst_idle", 64'(state_o), 64'd0);

    step(rsamp(), 1'b1, 1'b1);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 63) == 0)  user_codes = (NU*PW)'($urandom);
      if ($urandom_range(0, 149) == 0) user_en = NU'($urandom);
      if ($urandom_range(0, 63) == 0)  thresh = AW'($urandom_range(0, 900));
      step(rsamp(), $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
    end

    repeat (4) step(0, 1'b0, 1'b0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
